// File: rtl/maxpool_sched.sv
// rtl/maxpool_sched.sv - 2x2 max-pool read/write scheduler
// Optional DRAIN watchdog enabled by defining MAXPOOL_SCHED_WDOG_EN.
module maxpool_sched #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 10,
    parameter int DIMW   = 6
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [DIMW-1:0]   i_img_w,
    input  logic [DIMW-1:0]   i_img_h,
    input  logic [AWIDTH-1:0] i_src_base,
    input  logic [AWIDTH-1:0] i_dst_base,
    output logic              o_rd_en,
    output logic [AWIDTH-1:0] o_rd_addr,
    input  logic [DWIDTH-1:0] i_rd_data,
    output logic              o_mp_en,
    output logic              o_mp_valid,
    output logic [DWIDTH-1:0] o_mp_data,
    input  logic              i_mp_valid_out,
    input  logic [DWIDTH-1:0] i_mp_out,
    output logic              o_wr_en,
    output logic [AWIDTH-1:0] o_wr_addr,
    output logic [DWIDTH-1:0] o_wr_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);
    localparam int KW = 2*DIMW - 2;
    localparam int HW = DIMW - 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t            r_state;
    logic [AWIDTH-1:0] r_w;
    logic [AWIDTH-1:0] r_dst;
    logic [AWIDTH-1:0] r_win_addr;
    logic [AWIDTH-1:0] r_rd_addr;
    logic [AWIDTH-1:0] r_wr_addr;
    logic [HW-1:0]     r_wc;
    logic [HW-1:0]     r_wr;
    logic [HW-1:0]     r_wc_max;
    logic [HW-1:0]     r_wr_max;
    logic [1:0]        r_phase;
    logic [KW-1:0]     r_nwin;
    logic [KW-1:0]     r_k;
    logic [DWIDTH-1:0] r_wr_data;
    logic              r_rd_en;
    logic              r_mp_en;
    logic              r_mp_valid;
    logic              r_wr_en;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
`ifdef MAXPOOL_SCHED_WDOG_EN
    logic [4:0]        r_wdog;
`endif

    logic              w_dim_ok;
    logic              w_last_col;
    logic              w_last_row;
    logic              w_last_read;
    logic              w_take;
    logic [AWIDTH-1:0] w_next_win;

    assign w_dim_ok    = (i_img_w != '0) && !i_img_w[0] && (i_img_h != '0) && !i_img_h[0];
    assign w_last_col  = (r_wc == r_wc_max);
    assign w_last_row  = (r_wr == r_wr_max);
    assign w_last_read = (r_phase == 2'd3) && w_last_col && w_last_row;
    assign w_take      = i_mp_valid_out && (r_state == S_ISSUE || r_state == S_DRAIN);
    // After the last window of a row pair, origin jumps back 2C and down two rows: +w+2.
    assign w_next_win  = r_win_addr + (w_last_col ? r_w + AWIDTH'(2) : AWIDTH'(2));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_w        <= '0;
            r_dst      <= '0;
            r_win_addr <= '0;
            r_rd_addr  <= '0;
            r_wr_addr  <= '0;
            r_wc       <= '0;
            r_wr       <= '0;
            r_wc_max   <= '0;
            r_wr_max   <= '0;
            r_phase    <= '0;
            r_nwin     <= '0;
            r_k        <= '0;
            r_wr_data  <= '0;
            r_rd_en    <= 1'b0;
            r_mp_en    <= 1'b0;
            r_mp_valid <= 1'b0;
            r_wr_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
`ifdef MAXPOOL_SCHED_WDOG_EN
            r_wdog     <= '0;
`endif
        end else begin
            r_done     <= 1'b0;
            r_mp_valid <= r_rd_en;
            r_wr_en    <= w_take;
            if (w_take) begin
                r_wr_addr <= r_dst + AWIDTH'(r_k);
                r_wr_data <= i_mp_out;
                r_k       <= r_k + KW'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_busy <= 1'b1;
                        if (w_dim_ok) begin
                            r_state    <= S_ISSUE;
                            r_w        <= AWIDTH'(i_img_w);
                            r_dst      <= i_dst_base;
                            r_win_addr <= i_src_base;
                            r_rd_addr  <= i_src_base;
                            r_wc_max   <= i_img_w[DIMW-1:1] - HW'(1);
                            r_wr_max   <= i_img_h[DIMW-1:1] - HW'(1);
                            r_wc       <= '0;
                            r_wr       <= '0;
                            r_phase    <= '0;
                            r_nwin     <= '0;
                            r_k        <= '0;
                            r_rd_en    <= 1'b1;
                            r_mp_en    <= 1'b1;
                            r_err      <= 1'b0;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    r_phase <= r_phase + 2'd1;
                    if (w_last_read) begin
                        r_rd_en <= 1'b0;
                        r_nwin  <= r_nwin + KW'(1);
                        r_state <= S_DRAIN;
`ifdef MAXPOOL_SCHED_WDOG_EN
                        r_wdog  <= '0;
`endif
                    end else begin
                        case (r_phase)
                            2'd0, 2'd2: r_rd_addr <= r_rd_addr + AWIDTH'(1);
                            2'd1:       r_rd_addr <= r_win_addr + r_w;
                            default: begin
                                r_rd_addr  <= w_next_win;
                                r_win_addr <= w_next_win;
                                r_nwin     <= r_nwin + KW'(1);
                                r_wc       <= w_last_col ? '0 : r_wc + HW'(1);
                                if (w_last_col)
                                    r_wr <= r_wr + HW'(1);
                            end
                        endcase
                    end
                end
                S_DRAIN: begin
                    if (r_k == r_nwin) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_mp_en <= 1'b0;
                    end
`ifdef MAXPOOL_SCHED_WDOG_EN
                    else if (!i_mp_valid_out && r_wdog == 5'd30) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_mp_en <= 1'b0;
                        r_err   <= 1'b1;
                    end
                    r_wdog <= i_mp_valid_out ? '0 : r_wdog + 5'd1;
`endif
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_rd_en    = r_rd_en;
    assign o_rd_addr  = r_rd_addr;
    assign o_mp_en    = r_mp_en;
    assign o_mp_valid = r_mp_valid;
    assign o_mp_data  = r_mp_valid ? i_rd_data : '0;
    assign o_wr_en    = r_wr_en;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_data  = r_wr_data;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_err      = r_err;
endmodule

// File: doc/maxpool_sched.md
MAXPOOL_SCHED -- requirements
Module: maxpool_sched

Interface
REQ-001 Parameter DWIDTH, default 8: pixel data width.
REQ-002 Parameter AWIDTH, default 10: feature-buffer and result-buffer address width.
REQ-003 Parameter DIMW, default 6: width of the image-dimension inputs.
REQ-004 clk  in  1: single clock; all logic on rising edge.
REQ-005 reset  in  1: synchronous, active-high reset.
REQ-006 start  in  1: one-cycle pulse that launches a pooling job; sampled only in IDLE.
REQ-007 img_w, img_h  in  DIMW each: feature-map width and height in pixels; captured on start.
REQ-008 src_base, dst_base  in  AWIDTH each: source and destination base addresses; captured on start.
REQ-009 rd_en, rd_addr  out  1 / AWIDTH: feature-buffer read strobe and address.
REQ-010 rd_data  in  DWIDTH: read data, valid exactly 1 cycle after rd_en.
REQ-011 mp_en, mp_valid, mp_data  out  1 / 1 / DWIDTH: drive the pooling engine's en_maxpool, valid_in and data_in.
REQ-012 mp_valid_out, mp_out  in  1 / DWIDTH: pooling-engine result strobe and value; one result per 4 accepted samples.
REQ-013 wr_en, wr_addr, wr_data  out  1 / AWIDTH / DWIDTH: result-buffer write port.
REQ-014 busy, done, err  out  1 each: job active; one-cycle completion pulse; sticky error flag.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, DRAIN and DONE.
REQ-016 IDLE->ISSUE on start, with img_w and img_h both even and >=2; the block captures all config inputs and clears err.
REQ-017 IDLE->DONE on start with an odd or zero dimension; err=1; no read is issued.
REQ-018 ISSUE: one rd_en per cycle, no gaps; windows are visited row-major (window row R, window column C).
REQ-019 ISSUE: each window is read in the order (2R,2C), (2R,2C+1), (2R+1,2C), (2R+1,2C+1).
REQ-020 rd_addr SHALL equal src_base + row*img_w + col, computed incrementally with no multiplier; the sum wraps modulo 2^AWIDTH.
REQ-021 mp_valid SHALL equal rd_en delayed 1 cycle, and mp_data SHALL equal rd_data.
REQ-022 mp_en SHALL be 1 from entry to ISSUE until exit from DRAIN, and 0 otherwise.
REQ-023 ISSUE->DRAIN in the cycle after the last read, after exactly 4*(img_w/2)*(img_h/2) reads.
REQ-024 Each mp_valid_out=1 in ISSUE or DRAIN SHALL produce, 1 cycle later, wr_en=1, wr_data=mp_out and wr_addr=dst_base+k, where k counts results from 0.
REQ-025 mp_valid_out is ignored in IDLE and DONE.
REQ-026 DRAIN->DONE when the result count reaches (img_w/2)*(img_h/2) and the final write has issued.
REQ-027 DONE: done=1 for exactly 1 cycle, then the FSM returns to IDLE.
REQ-028 busy=1 in ISSUE, DRAIN and DONE.
REQ-029 A start pulse while busy=1 SHALL be ignored.
REQ-030 err SHALL hold its value until the next accepted start.
REQ-031 Counters SHALL be sized for a maximum of 2^(2*DIMW-2) results, with no overflow at img_w=img_h=2^DIMW-2 (largest even size).

Reset
REQ-032 On reset, the FSM goes to IDLE and all counters clear.
REQ-033 Reset values: rd_en, mp_en, mp_valid, wr_en, busy, done and err are 0; all address and data outputs are 0.
REQ-034 Reset mid-job SHALL abort the job immediately; no write is issued in the cycle after reset.

Configuration
REQ-035 Macro MAXPOOL_SCHED_WDOG_EN SHALL control a DRAIN watchdog.
REQ-036 With MAXPOOL_SCHED_WDOG_EN defined: a 5-bit counter clears on each mp_valid_out and on entry to DRAIN; if it reaches 31 in DRAIN, the FSM goes to DONE and sets err=1.
REQ-037 With MAXPOOL_SCHED_WDOG_EN undefined: no watchdog logic exists, and DRAIN waits indefinitely.

Verification
REQ-038 4x4 map holding 0..15, src_base=0, dst_base=100, with an ideal engine model -> 16 reads in the address order 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15; writes of 5,7,13,15 to addresses 100..103; one done pulse; err=0.
REQ-039 img_w=3, img_h=4 -> no rd_en, done pulse 1 cycle after start, err=1.
REQ-040 src_base=1020, 2x2 map (AWIDTH=10) -> rd_addr sequence 1020,1021,1022,1023; one write.
REQ-041 Second start pulse 3 cycles into a 4x4 job -> ignored; exactly 16 reads and 4 writes.
REQ-042 Reset asserted during ISSUE at read 7 -> next cycle all outputs at reset values; a fresh start then runs a full job.
REQ-043 With MAXPOOL_SCHED_WDOG_EN defined and the engine emitting only 3 of 4 results -> done and err asserted 31 cycles after the last result.
